spi_master_regif: RTL and testbench

//   SPI controller (mode 0, MSB first) that issues single register read/write

---
 rtl/spi_master_regif.sv | 130 +++++++++++++
 tb/tb_spi_master_regif.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_regif.sv
// SPI mode-0 master that runs one register read/write frame per request.
// Frame: {cmd byte, REG_W data bits}, MSB first. The first 8 bits returned
// by the slave are its status byte. The remaining bits are read data.
module spi_master_regif #(
    parameter int ADDR_W  = 3,
    parameter int REG_W   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [REG_W-1:0]  wdata,
    output logic              busy,
    output logic              done,
    output logic [REG_W-1:0]  rdata,
    output logic [7:0]        status,
    output logic              spi_cs_n,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int N    = 8 + REG_W;
    localparam int CMAX = (CLK_DIV > N) ? CLK_DIV : N;
    localparam int CW   = $clog2(CMAX) + 1;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;        // cycle within the current half-period / phase
    logic [CW-1:0]   bit_cnt;    // index of the bit currently on the wire
    logic [N-1:0]    tx_sr;
    logic [N-1:0]    rx_sr;
    logic [7:0]      cmd;
    logic [N-1:0]    frame;
    logic            rw_q;
    logic            phase_end;
    logic            last_bit;

    assign phase_end = (cnt == CW'(CLK_DIV - 1));
    assign last_bit  = (bit_cnt == CW'(N - 1));
    assign busy      = (state != S_IDLE);

    // Build the outgoing frame from the request inputs (used only on accept)
    always_comb begin
        cmd               = '0;
        cmd[ADDR_W-1:0]   = addr;
        cmd[7]            = rw;
        frame             = {cmd, (rw ? wdata : {REG_W{1'b0}})};
    end

    // Next-state logic: each phase lasts CLK_DIV cycles; SHIFT ends after the
    // low half of the last bit
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SETUP;
            S_SETUP: if (phase_end) state_nxt = S_SHIFT;
            S_SHIFT: if (phase_end && !spi_clk && last_bit) state_nxt = S_HOLD;
            S_HOLD:  if (phase_end) state_nxt = S_GAP;
            S_GAP:   if (phase_end) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, serial datapath and registered SPI pins
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rw_q     <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
            status   <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            cnt   <= (state == S_IDLE || phase_end) ? '0 : cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rw_q     <= rw;
                        tx_sr    <= frame;
                        rx_sr    <= '0;
                        bit_cnt  <= '0;
                        spi_cs_n <= 1'b0;
                        spi_mosi <= frame[N-1];
                    end
                end
                S_SETUP: begin
                    if (phase_end) spi_clk <= 1'b1;
                end
                S_SHIFT: begin
                    if (phase_end) begin
                        if (spi_clk) begin
                            // Sample at the end of the high half. Move mosi as sclk falls.
                            rx_sr    <= {rx_sr[N-2:0], spi_miso};
                            spi_clk  <= 1'b0;
                            spi_mosi <= tx_sr[N-2];
                            tx_sr    <= {tx_sr[N-2:0], 1'b0};
                        end else if (!last_bit) begin
                            spi_clk <= 1'b1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (phase_end) spi_cs_n <= 1'b1;
                end
                S_GAP: begin
                    if (phase_end) begin
                        status <= rx_sr[N-1 -: 8];
                        if (!rw_q) rdata <= rx_sr[REG_W-1:0];
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_regif.sv
// Bench for spi_master_regif: behavioural register-slave on the SPI pins,
// a reference register map, and timing expectations derived from frame length.
module tb_spi_master_regif;

    localparam int ADDR_W = 3;
    localparam int REG_W  = 8;
    localparam int CD     = 4;
    localparam int N      = 8 + REG_W;
    localparam int LAT    = (2 * N + 3) * CD;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              rw = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [REG_W-1:0]  wdata = '0;
    logic              busy, done, spi_cs_n, spi_clk, spi_mosi, spi_miso;
    logic [REG_W-1:0]  rdata;
    logic [7:0]        status;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] ref_mem [8];
    logic [7:0] exp_rd;

    // slave-side state
    logic [7:0]  slv_mem [8];
    logic [15:0] slv_tx, slv_rx;
    int          slv_nbits;

    int   mosi_viol = 0;
    logic pm, pc;

    always #5 clk = ~clk;

    spi_master_regif #(.ADDR_W(ADDR_W), .REG_W(REG_W), .CLK_DIV(CD)) u_dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .status(status),
        .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // spireg-style slave: status byte = mem[0], read data = mem[addr],
    // writes commit when cs_n rises after a complete frame
    initial begin
        logic pcs, pclk;
        pcs = 1'b1; pclk = 1'b0; spi_miso = 1'b0;
        slv_tx = '0; slv_rx = '0; slv_nbits = 0;
        for (int i = 0; i < 8; i++) slv_mem[i] = 8'h00;
        forever begin
            @(spi_cs_n or spi_clk);
            if (pcs === 1'b1 && spi_cs_n === 1'b0) begin
                slv_nbits = 0;
                slv_rx    = '0;
                slv_tx    = {slv_mem[0], 8'h00};
                spi_miso  = slv_tx[15];
            end else if (pcs === 1'b0 && spi_cs_n === 1'b1) begin
                if (slv_nbits == N && slv_rx[15]) slv_mem[slv_rx[10:8]] = slv_rx[7:0];
            end
            if (spi_cs_n === 1'b0 && pclk === 1'b0 && spi_clk === 1'b1) begin
                slv_rx = {slv_rx[14:0], spi_mosi};
                slv_nbits++;
                if (slv_nbits == 8) slv_tx[7:0] = slv_rx[7] ? 8'h00 : slv_mem[slv_rx[2:0]];
            end
            if (spi_cs_n === 1'b0 && pclk === 1'b1 && spi_clk === 1'b0)
                spi_miso = (slv_nbits < N) ? slv_tx[4'(15 - slv_nbits)] : 1'b0;
            pcs  = spi_cs_n;
            pclk = spi_clk;
        end
    end

    // mosi must hold steady while sclk is high
    always @(negedge clk) begin
        if (pc === 1'b1 && spi_clk === 1'b1 && spi_mosi !== pm) mosi_viol++;
        pm = spi_mosi;
        pc = spi_clk;
    end

    task automatic run_frame(input logic r, input logic [2:0] a, input logic [7:0] d, input bit spam);
        logic [15:0] ef;
        logic [7:0]  es, er;
        int n, gap, extra;
        ef = {r, 4'b0000, a, (r ? d : 8'h00)};
        es = ref_mem[0];
        er = r ? exp_rd : ref_mem[a];
        @(negedge clk); start = 1'b1; rw = r; addr = a; wdata = d;
        @(negedge clk); start = spam;
        chk("cs_low", spi_cs_n, 0);
        chk("busy", busy, 1);
        chk("mosi_msb", spi_mosi, ef[15]);
        n = 0; gap = 0;
        while (!done && n < LAT + 50) begin
            @(negedge clk); n++;
            if (!done) begin
                if (spi_cs_n) gap++;
                start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        start = 1'b0;
        chk("latency", n, LAT);
        chk("done", done, 1);
        chk("busy_at_done", busy, 0);
        chk("cs_gap", gap, CD);
        chk("mosi_frame", slv_rx, ef);
        chk("sclk_rises", slv_nbits, N);
        chk("status", status, es);
        chk("rdata", rdata, er);
        extra = 0;
        repeat (2 * CD + 4) begin
            @(negedge clk);
            if (!spi_cs_n || done || busy) extra++;
        end
        chk("idle_after", extra, 0);
        if (r) ref_mem[a] = d;
        exp_rd = er;
    endtask

    task automatic reset_mid_frame();
        int n, extra;
        @(negedge clk); start = 1'b1; rw = 1'b0; addr = 3'd2;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (slv_nbits != 7 && n < 1000) begin @(negedge clk); n++; end
        chk("t4_reach_bit6", slv_nbits, 7);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("t4_cs_n", spi_cs_n, 1);
        chk("t4_sclk", spi_clk, 0);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_status", status, 0);
        chk("t4_rdata", rdata, 0);
        extra = 0;
        repeat (LAT) begin
            @(negedge clk);
            if (done || !spi_cs_n) extra++;
        end
        chk("t4_quiet", extra, 0);
        exp_rd = 8'h00;
    endtask

    task automatic back_to_back(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] es, er;
        int n, gap;
        @(negedge clk); start = 1'b1; rw = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        n = 0; gap = 0;
        while (!done && n < LAT + 50) begin
            @(negedge clk); n++;
            if (spi_cs_n) gap++;
        end
        chk("b2b_lat1", n, LAT);
        ref_mem[a] = d;
        es = ref_mem[0];
        er = ref_mem[a];
        rw = 1'b0;
        @(negedge clk); start = 1'b0;
        chk("b2b_cs_low", spi_cs_n, 0);
        chk("b2b_gap", gap, CD + 1);
        n = 0;
        while (!done && n < LAT + 50) begin @(negedge clk); n++; end
        chk("b2b_lat2", n, LAT);
        chk("b2b_status", status, es);
        chk("b2b_rdata", rdata, er);
        exp_rd = er;
        repeat (2 * CD + 2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
        exp_rd = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_sclk", spi_clk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_status", status, 0);
        rst = 1'b0;

        run_frame(1'b1, 3'd3, 8'hA5, 1'b0);   // write, rdata stays 0
        run_frame(1'b1, 3'd0, 8'h5A, 1'b0);
        run_frame(1'b1, 3'd5, 8'hC3, 1'b0);
        run_frame(1'b0, 3'd5, 8'h00, 1'b0);   // status 5A, rdata C3
        run_frame(1'b0, 3'd3, 8'h00, 1'b1);   // start hammered while busy
        reset_mid_frame();
        run_frame(1'b0, 3'd5, 8'h00, 1'b0);
        back_to_back(3'd6, 8'($urandom));
        run_frame(1'b1, 3'd1, 8'h3C, 1'b0);
        run_frame(1'b0, 3'd1, 8'h00, 1'b0);
        run_frame(1'b1, 3'd0, 8'h81, 1'b0);
        run_frame(1'b0, 3'd2, 8'h00, 1'b0);   // status 81
        repeat (16)
            run_frame(1'($urandom), 3'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
        chk("mosi_stable_high", mosi_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
